// File: rtl/note_fetch_t.sv
// Note fetch stage: streams per-column note words from the note BRAM into
// 2-deep prefetch buffers, arbitrating round-robin with one read in flight.
module note_fetch_t #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 24,
  parameter int MEM_LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RESET_L,
  input  logic                sig_fetch_on,
  input  logic [4*ADDR_W-1:0] base_addr_in,
  input  logic [4*ADDR_W-1:0] size_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic [3:0]          note_rd,
  output logic [4*DATA_W-1:0] note_data,
  output logic [3:0]          note_valid,
  output logic [3:0]          col_end,
  output logic                sig_fetch_done
);

  localparam int WC_W = $clog2(MEM_LATENCY + 2);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q  [4], base_d  [4];
  logic [ADDR_W-1:0]   size_q  [4], size_d  [4];
  logic [ADDR_W-1:0]   idx_q   [4], idx_d   [4];
  logic [DATA_W-1:0]   fifo0_q [4], fifo0_d [4];
  logic [DATA_W-1:0]   fifo1_q [4], fifo1_d [4];
  logic [1:0]          cnt_q   [4], cnt_d   [4];
  logic [1:0]          rr_q, rr_d, sel_q, sel_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                active_q, active_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_en_q, mem_en_d;
  logic                done_q, done_d;

  logic                found;
  logic [1:0]          pick, cc;
  logic [3:0]          pop_v, psh_v;

  always_comb begin
    col_end    = '0;
    note_valid = '0;
    note_data  = '0;
    pop_v      = '0;
    psh_v      = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      col_end[c]    = active_q && (idx_q[c] == size_q[c]) && (cnt_q[c] == 2'd0);
      note_valid[c] = (cnt_q[c] != 2'd0);
      note_data[c*DATA_W +: DATA_W] = fifo0_q[c];
      pop_v[c]      = note_rd[c] && (cnt_q[c] != 2'd0);
      psh_v[c]      = (state_q == S_CAPTURE) && (sel_q == 2'(c));
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    idx_d      = idx_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    wcnt_d     = wcnt_q;
    active_d   = active_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = 1'b0;
    done_d     = done_q | (active_q & (&col_end));

    found = 1'b0;
    pick  = rr_q;
    cc    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cc = rr_q + 2'(k);
      if (!found && (idx_q[cc] < size_q[cc]) && (cnt_q[cc] < 2'd2)) begin
        found = 1'b1;
        pick  = cc;
      end
    end

    // Head always lives in slot 0; a push with a concurrent pop lands behind the survivor.
    for (int unsigned c = 0; c < 4; c++) begin
      case ({psh_v[c], pop_v[c]})
        2'b01: begin
          fifo0_d[c] = fifo1_q[c];
          cnt_d[c]   = cnt_q[c] - 2'd1;
        end
        2'b10: begin
          if (cnt_q[c] == 2'd0) fifo0_d[c] = mem_data;
          else                  fifo1_d[c] = mem_data;
          cnt_d[c] = cnt_q[c] + 2'd1;
        end
        2'b11: begin
          if (cnt_q[c] == 2'd1) begin
            fifo0_d[c] = mem_data;
          end else begin
            fifo0_d[c] = fifo1_q[c];
            fifo1_d[c] = mem_data;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: ;
      S_ARB: begin
        if (found) begin
          mem_addr_d = base_q[pick] + idx_q[pick];
          mem_en_d   = 1'b1;
          sel_d      = pick;
          wcnt_d     = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // One extra cycle beyond the BRAM latency so capture samples settled data.
        if (wcnt_q == WC_W'(MEM_LATENCY)) state_d = S_CAPTURE;
        else                              wcnt_d  = wcnt_q + WC_W'(1);
      end
      S_CAPTURE: begin
        idx_d[sel_q] = idx_q[sel_q] + ADDR_W'(1);
        rr_d         = sel_q + 2'd1;
        state_d      = S_ARB;
      end
      default: state_d = S_IDLE;
    endcase

    if (sig_fetch_on) begin
      for (int unsigned c = 0; c < 4; c++) begin
        base_d[c] = base_addr_in[c*ADDR_W +: ADDR_W];
        size_d[c] = size_in[c*ADDR_W +: ADDR_W];
        idx_d[c]  = '0;
        cnt_d[c]  = '0;
      end
      rr_d     = '0;
      active_d = 1'b1;
      done_d   = 1'b0;
      mem_en_d = 1'b0;
      state_d  = S_ARB;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= S_IDLE;
      for (int unsigned c = 0; c < 4; c++) begin
        base_q[c]  <= '0;
        size_q[c]  <= '0;
        idx_q[c]   <= '0;
        fifo0_q[c] <= '0;
        fifo1_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      rr_q       <= '0;
      sel_q      <= '0;
      wcnt_q     <= '0;
      active_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      wcnt_q     <= wcnt_d;
      active_q   <= active_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_en         = mem_en_q;
  assign sig_fetch_done = done_q;

endmodule

// File: tb/tb_note_fetch_t.sv
// Scoreboard bench for note_fetch_t: per-column expected note streams are
// built from the tables at start; a monitor checks every accepted pop.
module tb_note_fetch_t;
  localparam int AW = 13;
  localparam int DW = 24;
  localparam int ML = 2;

  logic            CLK = 1'b0;
  logic            RESET_L = 1'b0;
  logic            sig_fetch_on = 1'b0;
  logic [4*AW-1:0] base_addr_in = '0;
  logic [4*AW-1:0] size_in = '0;
  logic [AW-1:0]   mem_addr;
  logic            mem_en;
  logic [DW-1:0]   mem_data = '0;
  logic [3:0]      note_rd = '0;
  logic [4*DW-1:0] note_data;
  logic [3:0]      note_valid;
  logic [3:0]      col_end;
  logic            sig_fetch_done;

  note_fetch_t #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .sig_fetch_on(sig_fetch_on),
    .base_addr_in(base_addr_in), .size_in(size_in),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .note_rd(note_rd), .note_data(note_data), .note_valid(note_valid),
    .col_end(col_end), .sig_fetch_done(sig_fetch_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_total = 0;
  int pop_mode = 0;
  logic [3:0] manual_rd = '0;
  logic [DW-1:0] exp_q [4][$];
  logic [AW-1:0] rd_log [$];
  int exp_log [$];
  logic [DW-1:0] bram_p1 = '0;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {7'd0, a, 4'd0};
  endfunction

  function automatic logic [4*AW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BRAM with content word = addr*0x10, two registered stages, holds last read
  always @(posedge CLK) begin
    if (mem_en) bram_p1 <= word(mem_addr);
    mem_data <= bram_p1;
  end

  always @(posedge CLK) begin
    #1;
    case (pop_mode)
      1:       note_rd = note_valid;
      2:       note_rd = 4'($urandom);
      3:       note_rd = manual_rd;
      default: note_rd = '0;
    endcase
  end

  always @(negedge CLK) begin
    if (mem_en) rd_log.push_back(mem_addr);
    if (RESET_L && !sig_fetch_on) begin
      for (int c = 0; c < 4; c++) begin
        if (note_rd[c] && note_valid[c]) begin
          if (exp_q[c].size() == 0) check($sformatf("col%0d_pop_avail", c), exp_q[c].size(), 1);
          else check($sformatf("col%0d_pop_data", c), note_data[c*DW +: DW], exp_q[c].pop_front());
        end
      end
    end
  end

  task automatic start(input logic [4*AW-1:0] b, input logic [4*AW-1:0] s);
    @(posedge CLK); #1;
    base_addr_in = b;
    size_in      = s;
    sig_fetch_on = 1'b1;
    rd_log.delete();
    exp_total = 0;
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      for (int i = 0; i < int'(s[c*AW +: AW]); i++)
        exp_q[c].push_back(word(b[c*AW +: AW] + AW'(i)));
      exp_total += int'(s[c*AW +: AW]);
    end
    @(posedge CLK); #1;
    sig_fetch_on = 1'b0;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!mem_en && n < 100);
    check({name, "_issue"}, mem_en, 1);
  endtask

  task automatic check_log(input string name);
    check({name, "_nreads"}, rd_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < rd_log.size(); i++)
      check($sformatf("%s_rd%0d", name, i), rd_log[i], exp_log[i]);
  endtask

  task automatic finish_check(input string name);
    int n = 0;
    while (!sig_fetch_done && n < 2000) begin @(negedge CLK); n++; end
    check({name, "_done"}, sig_fetch_done, 1);
    check({name, "_col_end"}, col_end, 4'hF);
    check({name, "_reads"}, rd_log.size(), exp_total);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_col%0d_left", name, c), exp_q[c].size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 RESET_L = 1'b1;
    @(negedge CLK);
    check("reset_outputs", {mem_en, mem_addr, note_valid, note_data, col_end, sig_fetch_done}, '0);
    repeat (100) @(negedge CLK);
    check("idle_no_reads", rd_log.size(), 0);

    // basic stream, no pops
    pop_mode = 0;
    start(pack4(1, 5, 6, 9), pack4(3, 0, 2, 1));
    @(negedge CLK);
    check("basic_col_end_size0", col_end, 4'b0010);
    wait_rd("basic");
    n = 0;
    while (!note_valid[0] && n < 20) begin @(negedge CLK); n++; end
    check("basic_latency", n, ML + 2);
    repeat (40) @(negedge CLK);
    exp_log.delete();
    exp_log.push_back(1); exp_log.push_back(6); exp_log.push_back(9);
    exp_log.push_back(2); exp_log.push_back(7);
    check_log("basic");
    check("basic_valid", note_valid, 4'b1101);
    check("basic_col0", note_data[0*DW +: DW], 24'h10);
    check("basic_col2", note_data[2*DW +: DW], 24'h60);
    check("basic_col3", note_data[3*DW +: DW], 24'h90);

    // drain
    pop_mode = 1;
    finish_check("drain");
    exp_log.push_back(3);
    check_log("drain");
    repeat (10) @(negedge CLK);
    check("drain_done_sticky", sig_fetch_done, 1);

    // push and pop landing on the same edge with one word buffered
    pop_mode = 3;
    manual_rd = '0;
    start(pack4(100, 0, 0, 0), pack4(4, 0, 0, 0));
    n = 0;
    do begin @(negedge CLK); n++; end while (!(mem_en && mem_addr == AW'(101)) && n < 100);
    check("pushpop_issue101", mem_addr, 101);
    repeat (2) @(negedge CLK);
    manual_rd = 4'b0001;
    @(negedge CLK);
    manual_rd = '0;
    @(negedge CLK);
    check("pushpop_valid", note_valid[0], 1);
    check("pushpop_head", note_data[0*DW +: DW], word(101));
    pop_mode = 1;
    finish_check("pushpop");

    // restart while a read is in flight
    start(pack4(500, 600, 700, 800), pack4(3, 3, 3, 3));
    wait_rd("restart_first");
    start(pack4(0, 0, 20, 0), pack4(0, 0, 1, 0));
    @(negedge CLK);
    check("restart_col_end", col_end, 4'b1011);
    check("restart_done_clear", sig_fetch_done, 0);
    finish_check("restart");
    exp_log.delete();
    exp_log.push_back(20);
    check_log("restart");

    // address wrap
    start(pack4(8190, 0, 0, 0), pack4(4, 0, 0, 0));
    finish_check("wrap");
    exp_log.delete();
    exp_log.push_back(8190); exp_log.push_back(8191);
    exp_log.push_back(0); exp_log.push_back(1);
    check_log("wrap");

    // randomized tables with random (sometimes invalid) pops
    pop_mode = 2;
    for (int t = 0; t < 6; t++) begin
      start(pack4($urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191)),
            pack4($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5)));
      finish_check($sformatf("rand%0d", t));
    end

    // asynchronous reset in the middle of a read
    pop_mode = 0;
    start(pack4(40, 0, 0, 0), pack4(2, 0, 0, 0));
    wait_rd("midreset");
    @(posedge CLK);
    #3 RESET_L = 1'b0;
    #1;
    check("midreset_outputs", {mem_en, mem_addr, note_valid, note_data, col_end, sig_fetch_done}, '0);
    @(posedge CLK);
    #1 RESET_L = 1'b1;
    rd_log.delete();
    repeat (20) @(negedge CLK);
    check("midreset_no_reads", rd_log.size(), 0);
    check("midreset_no_valid", note_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
